// File: rtl/serial_word_loader_pkg.sv
// Shared types for the serial-to-parallel word loader.
package serial_word_loader_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } sloader_state_t;

endpackage

// File: rtl/serial_word_loader.sv
// Assembles an N-bit word from a serial bit stream and offers it on a
// single-buffered valid/ready port feeding a chip-enable register stage.
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sin_valid,
    input  logic                     sin_data,
    output logic                     sin_ready,
    input  logic                     flush,
    output logic [N-1:0]             dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(N+1)-1:0]   bit_count
);

    localparam int CW = $clog2(N + 1);
    // The final bit of a word goes straight into dout, so only N-1 bits are kept.
    localparam int PW = (N > 1) ? (N - 1) : 1;

    sloader_state_t state_r;
    logic [PW-1:0]  part_r;
    logic [N-1:0]   dout_r;
    logic [CW-1:0]  count_r;

    logic [N-1:0]   shifted_s;
    logic [PW-1:0]  part_next_s;
    logic           acc_s;
    logic           wacc_s;
    logic           last_bit_s;

    generate
        if (N == 1) begin : g_one
            assign shifted_s   = sin_data;
            assign part_next_s = 1'b0;
        end else if (MSB_FIRST) begin : g_msb
            assign shifted_s   = {part_r, sin_data};
            assign part_next_s = shifted_s[N-2:0];
        end else begin : g_lsb
            assign shifted_s   = {sin_data, part_r};
            assign part_next_s = shifted_s[N-1:1];
        end
    endgenerate

    assign dout_valid = (state_r == FULL);
    assign dout       = dout_r;
    assign bit_count  = count_r;
    assign acc_s      = sin_valid & sin_ready;
    assign wacc_s     = dout_valid & dout_ready;
    assign last_bit_s = (count_r == CW'(N - 1));

    // Input may be taken while collecting, or while full if the word leaves this cycle.
    always_comb begin
        sin_ready = 1'b0;
        case (state_r)
            COLLECT: sin_ready = 1'b1;
            FULL:    sin_ready = dout_ready;
            default: sin_ready = 1'b0;
        endcase
    end

    // Counter, shifter and collect/full state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= COLLECT;
            part_r  <= '0;
            dout_r  <= '0;
            count_r <= '0;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (flush) begin
                        count_r <= '0;
                        part_r  <= '0;
                    end else if (acc_s) begin
                        part_r <= part_next_s;
                        if (last_bit_s) begin
                            count_r <= '0;
                            dout_r  <= shifted_s;
                            state_r <= FULL;
                        end else begin
                            count_r <= count_r + CW'(1);
                        end
                    end
                end
                FULL: begin
                    // flush never discards the held word; it only drops a coincident bit.
                    if (flush) begin
                        part_r <= '0;
                    end
                    if (wacc_s) begin
                        if (acc_s && !flush) begin
                            part_r <= part_next_s;
                            if (N == 1) begin
                                dout_r <= shifted_s;
                            end else begin
                                count_r <= CW'(1);
                                state_r <= COLLECT;
                            end
                        end else begin
                            state_r <= COLLECT;
                        end
                    end
                end
                default: begin
                    state_r <= COLLECT;
                    count_r <= '0;
                end
            endcase
        end
    end

endmodule
